serv_dbus_byte_bridge: RTL and testbench
========================================

# serv_dbus_byte_bridge

Converts the 32-bit Wishbone-classic data bus of the SERV core into a sequence of single-byte accesses on an 8-bit memory port, for external byte-wide SRAM or SPI-RAM controllers. Sits directly downstream of the memory interface stage. Only byte lanes flagged in `i_wb_sel` are accessed, lowest lane first, and read bytes are assembled into the lane positions the core's memory interface expects. Exactly one Wishbone acknowledge is returned per transaction.

## Interface
- `AW`, default 16: byte-address width of the memory port.

Ports:
- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_wb_adr`  in  32  byte address; bits [1:0] ignored, bits [AW-1:2] used.
- `i_wb_dat`  in  32  write data, lane n = bits [8n+7:8n].
- `i_wb_sel`  in  4  byte-lane enables.
- `i_wb_we`  in  1  1 = write, 0 = read.
- `i_wb_cyc`  in  1  transaction request; held high until ack.
- `o_wb_rdt`  out  32  assembled read data.
- `o_wb_ack`  out  1  one-cycle transaction acknowledge.
- `o_mem_req`  out  1  byte access request.
- `o_mem_we`  out  1  byte access is a write.
- `o_mem_adr`  out  AW  byte address.
- `o_mem_wdat`  out  8  write byte.
- `i_mem_rdat`  in  8  read byte; valid when `i_mem_ack` = 1.
- `i_mem_ack`  in  1  byte access complete; may be asserted in the same cycle as `o_mem_req`.

## Operation
- States: IDLE, XFER, ACK. Reset state: IDLE. All outputs, `o_wb_rdt` and the latched request are 0 under reset.
- IDLE, `i_wb_cyc` = 1:
  - Latch adr[AW-1:2], dat, sel and we.
  - If we = 0, clear `o_wb_rdt` to 0.
  - If sel ≠ 0, go to XFER with lane index = lowest set bit of sel; otherwise go to ACK.
- XFER:
  - `o_mem_req` = 1, `o_mem_we` = latched we, `o_mem_adr` = {adr[AW-1:2], lane}, `o_mem_wdat` = latched dat lane.
  - All memory outputs stay stable until `i_mem_ack`.
  - On `i_mem_ack`:
    - If a read, write `i_mem_rdat` into `o_wb_rdt` lane.
    - Clear that sel bit.
    - If sel bits remain, advance the lane to the next set bit and stay in XFER; `o_mem_req` stays high and the new address appears next cycle.
    - Otherwise go to ACK.
- ACK: `o_wb_ack` = 1 for exactly one cycle, then IDLE. Unselected read lanes read as 0.
- `o_wb_rdt` holds its value from ack until the next read transaction is latched.
- Master rule: `i_wb_cyc` must be low in the cycle after `o_wb_ack`. The bridge does not check this.
- Non-contiguous sel patterns (e.g. 1001) are legal; lanes 0 and 3 are accessed and 1 and 2 are skipped.
- `i_mem_ack` outside XFER is ignored. Input changes on the Wishbone side after latching are ignored until IDLE.
- Reset mid-transaction:
  - `o_mem_req` and `o_wb_ack` drop asynchronously.
  - No acknowledge is issued for the aborted transaction.
  - Partial memory writes already acked are not undone.

## Timing
- Cycle 0: IDLE samples `i_wb_cyc`.
- Cycle 1: first `o_mem_req`.
- Each byte occupies 1 + (wait cycles before `i_mem_ack`) cycles.
- `o_wb_ack` is asserted in the cycle after the last byte ack.
- Zero-wait memory:
  - word access: ack in cycle 5;
  - halfword: cycle 3;
  - byte: cycle 2;
  - sel = 0000: cycle 1, with no `o_mem_req`.
- Throughput: one transaction per (latency + 1) cycles, since IDLE is re-entered before the next request is sampled.

## Test plan
- Word write, zero-wait: adr 0x100, sel 1111, dat 0xDDCCBBAA.
  - Memory writes AA@0x100, BB@0x101, CC@0x102, DD@0x103 on consecutive cycles 1–4.
  - `o_wb_ack` in cycle 5 only.
- Halfword read: adr 0x202, sel 1100; memory returns 0x5A then 0xA5.
  - Reads at 0x202 and 0x203.
  - `o_wb_rdt` = 0xA55A0000 at ack.
- Byte write with wait states: sel 0010, dat 0x0000_7E00; memory asserts ack 3 cycles after req.
  - `o_mem_adr` = base+1 and `o_mem_wdat` = 0x7E, both stable all 4 cycles.
  - Ack in cycle 5.
- sel 0000: `o_mem_req` is never asserted; ack in cycle 1.
- sel 1001 read, returns 0x11 and 0x44.
  - Only lanes 0 and 3 are accessed.
  - `o_wb_rdt` = 0x44000011.
- Reset mid-transaction: deassert `i_rst_n` during the 2nd byte of a word write.
  - `o_mem_req` = 0 immediately; no ack.
  - After release, a new read completes normally.

Source files
------------

// File: rtl/serv_dbus_byte_bridge.sv
// serv_dbus_byte_bridge: splits 32-bit Wishbone accesses into single-byte memory accesses
module serv_dbus_byte_bridge #(
    parameter int AW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [31:0]   i_wb_adr,
    input  logic [31:0]   i_wb_dat,
    input  logic [3:0]    i_wb_sel,
    input  logic          i_wb_we,
    input  logic          i_wb_cyc,
    output logic [31:0]   o_wb_rdt,
    output logic          o_wb_ack,
    output logic          o_mem_req,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_adr,
    output logic [7:0]    o_mem_wdat,
    input  logic [7:0]    i_mem_rdat,
    input  logic          i_mem_ack
);
    typedef enum logic [1:0] {IDLE, XFER, ACK} state_t;
    state_t state, state_nx;
    logic [AW-3:0] adr_q;
    logic [31:0]   dat_q;
    logic [3:0]    sel_q, sel_rem;
    logic          we_q;
    logic [1:0]    lane;
    logic          unused;
    function automatic logic [1:0] low_lane(input logic [3:0] s);
        return s[0] ? 2'd0 : s[1] ? 2'd1 : s[2] ? 2'd2 : 2'd3;
    endfunction
    assign unused     = ^{i_wb_adr[31:AW], i_wb_adr[1:0]};
    assign sel_rem    = sel_q & ~(4'b1 << lane);
    assign o_mem_req  = state == XFER;
    assign o_wb_ack   = state == ACK;
    assign o_mem_we   = o_mem_req & we_q;
    assign o_mem_adr  = {adr_q, lane};
    assign o_mem_wdat = dat_q[8*lane +: 8];
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nx;
    always_comb begin
        state_nx = state;
        if (state == IDLE && i_wb_cyc) state_nx = |i_wb_sel ? XFER : ACK;
        else if (state == XFER && i_mem_ack && ~|sel_rem) state_nx = ACK;
        else if (state == ACK) state_nx = IDLE;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            adr_q    <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            lane     <= '0;
            o_wb_rdt <= '0;
        end else begin
            if (state == IDLE && i_wb_cyc) begin
                adr_q <= i_wb_adr[AW-1:2];
                dat_q <= i_wb_dat;
                sel_q <= i_wb_sel;
                we_q  <= i_wb_we;
                lane  <= low_lane(i_wb_sel);
                if (!i_wb_we) o_wb_rdt <= '0;
            end
            // each acked lane is retired so the next lowest remaining lane follows
            if (state == XFER && i_mem_ack) begin
                sel_q <= sel_rem;
                lane  <= low_lane(sel_rem);
                if (!we_q) o_wb_rdt[8*lane +: 8] <= i_mem_rdat;
            end
        end
    end
endmodule

// File: tb/tb_serv_dbus_byte_bridge.sv
// tb_serv_dbus_byte_bridge: scoreboard bench with a wait-state memory model
module tb_serv_dbus_byte_bridge;
    localparam int AW = 16;
    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [7:0]    dat;
    } acc_t;
    logic          i_clk = 1'b0, i_rst_n = 1'b0;
    logic [31:0]   i_wb_adr = '0, i_wb_dat = '0;
    logic [3:0]    i_wb_sel = '0;
    logic          i_wb_we = 1'b0, i_wb_cyc = 1'b0;
    logic [31:0]   o_wb_rdt;
    logic          o_wb_ack, o_mem_req, o_mem_we;
    logic [AW-1:0] o_mem_adr;
    logic [7:0]    o_mem_wdat;
    logic [7:0]    i_mem_rdat = '0;
    logic          i_mem_ack = 1'b0;
    acc_t          exp_q[$];
    logic [31:0]   rdt_q[$];
    int            n_chk = 0, n_fail = 0, wait_n = 0, wcnt = 0, req_cyc = 0;
    logic [31:0]   last_rdt = '0;

    serv_dbus_byte_bridge #(.AW(AW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel),
        .i_wb_we(i_wb_we), .i_wb_cyc(i_wb_cyc),
        .o_wb_rdt(o_wb_rdt), .o_wb_ack(o_wb_ack),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_adr(o_mem_adr),
        .o_mem_wdat(o_mem_wdat), .i_mem_rdat(i_mem_rdat), .i_mem_ack(i_mem_ack)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // memory model: acks the head access after wait_n wait cycles, random ack noise when idle
    initial forever begin
        @(negedge i_clk);
        if (o_mem_req) begin
            req_cyc++;
            if (exp_q.size() == 0) begin
                chk("unexpected_req", 32'd1, 32'd0);
                i_mem_ack = 1'b0;
            end else begin
                chk("mem_adr", 32'(o_mem_adr), 32'(exp_q[0].adr));
                chk("mem_we", 32'(o_mem_we), 32'(exp_q[0].we));
                if (exp_q[0].we) chk("mem_wdat", 32'(o_mem_wdat), 32'(exp_q[0].dat));
                if (wcnt == wait_n) begin
                    i_mem_ack  = 1'b1;
                    i_mem_rdat = exp_q[0].we ? 8'($urandom) : exp_q[0].dat;
                    void'(exp_q.pop_front());
                    wcnt = 0;
                end else begin
                    i_mem_ack  = 1'b0;
                    i_mem_rdat = 8'($urandom);
                    wcnt++;
                end
            end
        end else begin
            i_mem_ack  = 1'($urandom);
            i_mem_rdat = 8'($urandom);
            wcnt = 0;
        end
    end

    task automatic run(input logic [31:0] adr, input logic [31:0] dat, input logic [31:0] rd,
                       input logic [3:0] sel, input logic we, input int w);
        int n = 0;
        int base = req_cyc;
        int nb = $countones(sel);
        logic [31:0] exp_rdt = '0;
        for (int i = 0; i < 4; i++)
            if (sel[i]) begin
                exp_q.push_back('{we, {adr[AW-1:2], 2'(i)}, we ? dat[8*i +: 8] : rd[8*i +: 8]});
                exp_rdt[8*i +: 8] = rd[8*i +: 8];
            end
        rdt_q.push_back(we ? last_rdt : exp_rdt);
        if (!we) last_rdt = exp_rdt;
        wait_n = w;
        i_wb_adr = adr; i_wb_dat = dat; i_wb_sel = sel; i_wb_we = we; i_wb_cyc = 1'b1;
        @(posedge i_clk);
        #1;
        i_wb_adr = $urandom; i_wb_dat = $urandom; i_wb_sel = 4'($urandom); i_wb_we = 1'($urandom);
        do begin
            @(negedge i_clk);
            n++;
        end while (!o_wb_ack && n < 60);
        chk("ack_cycle", 32'(n), 32'(nb * (w + 1) + 1));
        chk("wb_rdt", o_wb_rdt, rdt_q.pop_front());
        chk("acc_left", 32'(exp_q.size()), 32'd0);
        chk("req_cycles", 32'(req_cyc - base), 32'(nb * (w + 1)));
        exp_q.delete();
        i_wb_cyc = 1'b0;
        @(negedge i_clk);
        chk("ack_pulse", 32'(o_wb_ack), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge i_clk);
        chk("rst_ack", 32'(o_wb_ack), 32'd0);
        chk("rst_req", 32'(o_mem_req), 32'd0);
        chk("rst_rdt", o_wb_rdt, 32'd0);
        chk("rst_adr", 32'(o_mem_adr), 32'd0);
        chk("rst_wdat", 32'(o_mem_wdat), 32'd0);
        chk("rst_we", 32'(o_mem_we), 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        run(32'h0000_0100, 32'hDDCC_BBAA, 32'h0, 4'b1111, 1'b1, 0);
        run(32'h0000_0202, 32'h0, 32'hA55A_0000, 4'b1100, 1'b0, 0);
        run(32'h0000_0300, 32'h0000_7E00, 32'h0, 4'b0010, 1'b1, 3);
        run(32'h0000_0400, 32'h1234_5678, 32'h0, 4'b0000, 1'b1, 0);
        run(32'h0000_0404, 32'h0, 32'h44_99_88_11, 4'b1001, 1'b0, 0);
        run(32'h0000_0408, 32'h0, 32'h0, 4'b0000, 1'b0, 0);
        run(32'hFFFF_1234, 32'h0, 32'hCAFE_F00D, 4'b1111, 1'b0, 1);
        run(32'h0000_0010, 32'h0000_BEEF, 32'h0, 4'b0011, 1'b1, 2);
        // abort a word write during its second byte
        wait_n = 0;
        for (int i = 0; i < 4; i++)
            exp_q.push_back('{1'b1, {14'h0140, 2'(i)}, 8'(8'h04 - 8'(i))});
        i_wb_adr = 32'h0000_0500; i_wb_dat = 32'h0102_0304; i_wb_sel = 4'b1111; i_wb_we = 1'b1;
        i_wb_cyc = 1'b1;
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        chk("mid_req", 32'(o_mem_req), 32'd1);
        chk("mid_adr", 32'(o_mem_adr), 32'h0501);
        #1;
        i_rst_n = 1'b0;
        #1;
        chk("abort_req", 32'(o_mem_req), 32'd0);
        chk("abort_ack", 32'(o_wb_ack), 32'd0);
        chk("abort_we", 32'(o_mem_we), 32'd0);
        i_wb_cyc = 1'b0;
        exp_q.delete();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        last_rdt = '0;
        repeat (3) begin
            @(negedge i_clk);
            chk("no_ack_after_abort", 32'(o_wb_ack), 32'd0);
            chk("no_req_after_abort", 32'(o_mem_req), 32'd0);
        end
        run(32'h0000_0040, 32'h0, 32'h8765_4321, 4'b1111, 1'b0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
